reg_pair_sequencer: RTL and testbench
=====================================

# reg_pair_sequencer

Front-end for the 8-bit register file that performs 16-bit register-pair operations (BC, DE, HL) over the register file's single 8-bit read/write port. Accepts one pair request at a time through a valid/ready handshake, issues the byte-wide read/write strobes in sequence, and returns the assembled 16-bit result as a one-cycle response pulse. Sits between the CPU control unit and the register file; the 16-bit address paths (LD rr,nn, INC rr, DEC rr, (HL+)/(HL-)) use it.

## Interface
Parameters: none. Register codes are fixed: B=3'b000, C=3'b001, D=3'b010, E=3'b011, H=3'b100, L=3'b101, A=3'b111.

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge
- req_op  input  2  00 READ, 01 WRITE, 10 INC, 11 DEC
- req_pair  input  2  00 BC, 01 DE, 10 HL, 11 reserved
- req_wdata  input  16  write value for WRITE ({hi, lo}); ignored otherwise
- resp_valid  output  1  one-cycle completion pulse; no backpressure
- resp_data  output  16  pair value: read value (READ), written value (WRITE), updated value (INC/DEC), 0 on error
- resp_err  output  1  valid with resp_valid; 1 for reserved pair
- busy  output  1  high in every state other than IDLE
- rf_wr_sel  output  3  register file write select
- rf_rd_sel  output  3  register file read select
- rf_wr_en  output  1  register file write enable; the file commits on the rising edge at the end of the cycle
- rf_rd_en  output  1  register file read enable; rf_rdata is combinational and valid in the same cycle
- rf_wdata  output  8  register file write data
- rf_rdata  input  8  register file read data; sampled only in cycles where rf_rd_en=1 (otherwise high-Z)

## Operation
- All outputs are registered or decoded from registered state.
- Reset values: req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_data=0, rf_wr_en=0, rf_rd_en=0, rf_wr_sel=0, rf_rd_sel=0, rf_wdata=0.
- On accept, latch op, pair, and wdata. hi/lo codes: BC→B/C, DE→D/E, HL→H/L.
- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE.
- Transitions:
  - READ: IDLE→RD_HI→RD_LO→DONE→IDLE.
  - WRITE: IDLE→WR_HI→WR_LO→DONE→IDLE.
  - INC/DEC: IDLE→RD_HI→RD_LO→WR_HI→WR_LO→DONE→IDLE.
  - Reserved pair (any op): IDLE→DONE→IDLE with resp_err=1 and resp_data=0. No rf strobes are issued.
- RD_HI / RD_LO: rf_rd_en=1, rf_rd_sel=hi/lo code; capture rf_rdata into the hi/lo byte at the rising edge. rf_wr_en=0.
- WR_HI / WR_LO: rf_wr_en=1, rf_wr_sel=hi/lo code, rf_wdata=hi/lo byte of the result. rf_rd_en=0.
- Result computation:
  - WRITE result = latched wdata.
  - INC result = captured value + 1, modulo 2^16. 0xFFFF→0x0000; carry from lo propagates into hi.
  - DEC result = captured value − 1, modulo 2^16. 0x0000→0xFFFF.
  - No flags are produced.
- DONE: resp_valid=1 and resp_data=result for exactly one cycle. req_ready returns high the following cycle; back-to-back requests are therefore separated by at least one IDLE cycle.
- Never assert rf_rd_en and rf_wr_en together. Never assert either outside RD_*/WR_* states.
- Reset mid-operation: immediately return to IDLE with all outputs at reset values and no further strobes. A pair whose WR_HI already committed keeps the new hi byte; recovery is the caller's responsibility.
- req_* inputs are ignored while busy.

## Timing
- Request accepted at rising edge N:
  - READ/WRITE: resp_valid high during cycle N+3.
  - INC/DEC: resp_valid high during cycle N+5.
  - Reserved pair: resp_valid high during cycle N+1.
- Write commit points: hi byte at the end of cycle N+1 (WRITE) or N+3 (INC/DEC); lo byte one cycle later.
- Read sample points: hi byte at the end of cycle N+1, lo byte at the end of cycle N+2.
- Maximum throughput: one READ/WRITE per 4 cycles; one INC/DEC per 6 cycles.

## Test plan
- Reset: hold rst=0 with req_valid=1 → req_ready=1, busy=0, all rf strobes 0, resp_valid never pulses. Release → idle state is maintained.
- WRITE DE=0x12AB, then READ DE → write strobes D←0x12 then E←0xAB. Read response resp_data=0x12AB at N+3, resp_err=0.
- HL=0x00FF, INC HL → resp_data=0x0100 at N+5. Register file H=0x01, L=0x00. Then DEC HL → 0x00FF.
- BC=0xFFFF, INC BC → 0x0000; then DEC BC → 0xFFFF. A and other pairs are unchanged.
- Reserved pair READ → resp_valid at N+1, resp_err=1, resp_data=0, no rf_rd_en/rf_wr_en. A request held during busy is not accepted until req_ready returns.
- Assert rst during WR_LO of WRITE HL=0xBEEF (HL was 0x1111) → outputs reset immediately. H=0xBE, L=0x11, no resp_valid pulse.

Source files
------------

// File: rtl/reg_pair_sequencer.sv
// reg_pair_sequencer: performs 16-bit register-pair READ/WRITE/INC/DEC over
// the 8-bit register file's single byte-wide read/write port.
module reg_pair_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_pair,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [2:0]  rf_wr_sel,
  output logic [2:0]  rf_rd_sel,
  output logic        rf_wr_en,
  output logic        rf_rd_en,
  output logic [7:0]  rf_wdata,
  input  logic [7:0]  rf_rdata
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_INC    = 2'b10;
  localparam logic [1:0] OP_DEC    = 2'b11;
  localparam logic [1:0] PAIR_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_HI = 3'd1,
    RD_LO = 3'd2,
    WR_HI = 3'd3,
    WR_LO = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [1:0]  pair_q;
  logic [7:0]  hi_q;
  logic [15:0] res_q;
  logic [15:0] rd_val;
  logic [15:0] upd;

  // BC/DE/HL map onto B/C, D/E, H/L: the pair code is the upper two bits.
  function automatic logic [2:0] hi_code(input logic [1:0] p);
    return {p, 1'b0};
  endfunction

  function automatic logic [2:0] lo_code(input logic [1:0] p);
    return {p, 1'b1};
  endfunction

  // Wrapping 16-bit increment/decrement; READ (and WRITE) pass the value through.
  function automatic logic [15:0] step(input logic [1:0] op, input logic [15:0] v);
    case (op)
      OP_INC:  return v + 16'd1;
      OP_DEC:  return v - 16'd1;
      default: return v;
    endcase
  endfunction

  // Pair value as it stands once the lo byte is on rf_rdata, and its update.
  always_comb begin
    rd_val = {hi_q, rf_rdata};
    upd    = step(op_q, rd_val);
  end

  // Request fields and byte captures; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      op_q   <= req_op;
      pair_q <= req_pair;
      res_q  <= req_wdata;
    end
    if (state == RD_HI) hi_q <= rf_rdata;
    if (state == RD_LO) res_q <= upd;
  end

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_wr_sel  <= '0;
      rf_rd_sel  <= '0;
      rf_wdata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_pair == PAIR_RSVD) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else if (req_op == OP_WRITE) begin
              state     <= WR_HI;
              rf_wr_en  <= 1'b1;
              rf_wr_sel <= hi_code(req_pair);
              rf_wdata  <= req_wdata[15:8];
            end else begin
              state     <= RD_HI;
              rf_rd_en  <= 1'b1;
              rf_rd_sel <= hi_code(req_pair);
            end
          end
        end
        RD_HI: begin
          state     <= RD_LO;
          rf_rd_sel <= lo_code(pair_q);
        end
        RD_LO: begin
          rf_rd_en <= 1'b0;
          if (op_q == OP_READ) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= upd;
          end else begin
            state     <= WR_HI;
            rf_wr_en  <= 1'b1;
            rf_wr_sel <= hi_code(pair_q);
            rf_wdata  <= upd[15:8];
          end
        end
        WR_HI: begin
          state     <= WR_LO;
          rf_wr_sel <= lo_code(pair_q);
          rf_wdata  <= res_q[7:0];
        end
        WR_LO: begin
          state      <= DONE;
          rf_wr_en   <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_data  <= res_q;
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          resp_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Scoreboard bench for reg_pair_sequencer with a behavioural register file.
module tb_reg_pair_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_pair;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [2:0]  rf_wr_sel;
  logic [2:0]  rf_rd_sel;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [7:0]  rf_wdata;
  logic [7:0]  rf_rdata;

  always #5 clk = ~clk;

  reg_pair_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_pair(req_pair), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy),
    .rf_wr_sel(rf_wr_sel), .rf_rd_sel(rf_rd_sel), .rf_wr_en(rf_wr_en),
    .rf_rd_en(rf_rd_en), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // Register file: eight bytes, write commits at the rising edge.
  logic [7:0] rf [8];
  logic [7:0] init_val [8];
  logic       init_done = 1'b0;
  logic [7:0] gm [8];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 8; i++) rf[i] <= init_val[i];
    end else if (rf_wr_en) begin
      rf[rf_wr_sel] <= rf_wdata;
    end
  end
  assign rf_rdata = rf_rd_en ? rf[rf_rd_sel] : 8'hA5;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        err;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d;
  } wr_t;
  wr_t wlog[$];
  int  rd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobe exclusivity, write/read logging, response scoreboard.
  always @(negedge clk) begin
    check("strobe_excl", {31'd0, rf_rd_en & rf_wr_en}, 32'd0);
    if (rf_wr_en) wlog.push_back('{rf_wr_sel, rf_wdata});
    if (rf_rd_en) rd_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got data %0h err %0b expected no response", resp_data, resp_err);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", {16'd0, resp_data}, {16'd0, mon_e.data});
        check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
        check("resp_time", cyc, mon_e.due);
      end
    end
  end

  // Reference: pair table, wrapping arithmetic, latency per operation class.
  function automatic void model(input logic [1:0] op, input logic [1:0] pair,
                                input logic [15:0] wd, output logic err,
                                output logic [15:0] data, output int lat);
    int h, l, v;
    err = 1'b0;
    h = 0;
    l = 1;
    case (pair)
      2'd0: begin h = 0; l = 1; end
      2'd1: begin h = 2; l = 3; end
      2'd2: begin h = 4; l = 5; end
      default: begin err = 1'b1; end
    endcase
    if (err) begin
      data = 16'h0000;
      lat  = 1;
      return;
    end
    v = gm[h] * 256 + gm[l];
    case (op)
      2'd0: lat = 3;
      2'd1: begin v = int'(wd); lat = 3; end
      2'd2: begin v = (v + 1) % 65536; lat = 5; end
      default: begin v = (v + 65535) % 65536; lat = 5; end
    endcase
    data  = 16'(v);
    gm[h] = data[15:8];
    gm[l] = data[7:0];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [1:0] pair, input logic [15:0] wd);
    exp_t e;
    int   lat;
    int   w;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_pair  = pair;
    req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, w);
      req_valid = 1'b0;
    end else begin
      model(op, pair, wd, e.err, e.data, lat);
      e.due = cyc + lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_pair  = 2'($urandom);
      req_wdata = 16'($urandom);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  int n0, r0, w;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_pair  = 2'b00;
    req_wdata = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      init_val[i] = 8'($urandom);
      gm[i]       = init_val[i];
    end

    // Reset held with a request pending: idle outputs, no accept.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {30'd0, rf_rd_en, rf_wr_en}, 32'd0);
    check("rst_resp", {15'd0, resp_valid, resp_err, resp_data}, 32'd0);
    check("rst_rf_bus", {11'd0, rf_wr_sel, rf_rd_sel, rf_wdata, 8'd0}, 32'd0);
    init_done = 1'b1;
    req_valid = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // WRITE DE then READ DE, with write strobe order.
    n0 = wlog.size();
    issue(2'b01, 2'b01, 16'h12AB);
    drain();
    check("de_wr_count", wlog.size() - n0, 32'd2);
    if (wlog.size() >= n0 + 2) begin
      check("de_wr_hi", {21'd0, wlog[n0].sel, wlog[n0].d}, {21'd0, 3'd2, 8'h12});
      check("de_wr_lo", {21'd0, wlog[n0+1].sel, wlog[n0+1].d}, {21'd0, 3'd3, 8'hAB});
    end
    issue(2'b00, 2'b01, 16'h0000);
    drain();

    // HL carry from lo into hi, then back down.
    issue(2'b01, 2'b10, 16'h00FF);
    issue(2'b10, 2'b10, 16'h0000);
    drain();
    check("hl_inc_h", {24'd0, rf[4]}, 32'h01);
    check("hl_inc_l", {24'd0, rf[5]}, 32'h00);
    issue(2'b11, 2'b10, 16'h0000);
    drain();

    // BC wrap both ways; A untouched.
    issue(2'b01, 2'b00, 16'hFFFF);
    issue(2'b10, 2'b00, 16'h0000);
    issue(2'b11, 2'b00, 16'h0000);
    drain();
    check("a_unchanged", {24'd0, rf[7]}, {24'd0, init_val[7]});

    // Reserved pair: error response, no strobes.
    n0 = wlog.size();
    r0 = rd_cnt;
    issue(2'b00, 2'b11, 16'h0000);
    drain();
    check("rsvd_no_wr", wlog.size() - n0, 32'd0);
    check("rsvd_no_rd", rd_cnt - r0, 32'd0);
    // Reserved WRITE, then a READ held while busy.
    issue(2'b01, 2'b11, 16'h1234);
    issue(2'b00, 2'b01, 16'h0000);
    drain();

    // Randomized mix, requests held back-to-back.
    for (int k = 0; k < 60; k++) begin
      issue(2'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
    end
    drain();

    // Reset during WR_LO of WRITE HL=0xBEEF over HL=0x1111.
    issue(2'b01, 2'b10, 16'h1111);
    drain();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_pair  = 2'b10;
    req_wdata = 16'hBEEF;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("mid_rst_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wr_lo_strobe", {28'd0, rf_wr_en, rf_wr_sel}, {28'd0, 1'b1, 3'd5});
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {30'd0, req_ready, busy}, {30'd0, 1'b1, 1'b0});
    check("mid_rst_strobes", {30'd0, rf_rd_en, rf_wr_en}, 32'd0);
    check("mid_rst_resp", {15'd0, resp_valid, resp_err, resp_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_h", {24'd0, rf[4]}, 32'hBE);
    check("mid_rst_l", {24'd0, rf[5]}, 32'h11);
    gm[4] = 8'hBE;
    gm[5] = 8'h11;

    // Whole register file against the pair-level model.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rf_final_%0d", i), {24'd0, rf[i]}, {24'd0, gm[i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
